// File: rtl/fdiv_prog_pkg.sv
// Shared constants for the programmable clock divider.
package fdiv_prog_pkg;

  localparam int FDIV_WIDTH_DEF = 16;

endpackage

// File: rtl/fdiv_prog_if.sv
// Control and observation bundle for fdiv_prog; the divider itself sits on the slave side.
interface fdiv_prog_if
  import fdiv_prog_pkg::*;
#(
  parameter int WIDTH = FDIV_WIDTH_DEF
);

  logic             en;
  logic             sync;
  logic             div_load;
  logic [WIDTH-1:0] div_in;
  logic             tick;
  logic             fout;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] count_q;

  modport master (
    output en, sync, div_load, div_in,
    input  tick, fout, div_q, count_q
  );

  modport slave (
    input  en, sync, div_load, div_in,
    output tick, fout, div_q, count_q
  );

endinterface

// File: rtl/fdiv_prog.sv
// Runtime-programmable divider: one-cycle tick every div_q enabled cycles, fout toggles per tick.
// Priority per edge is sync > div_load > en > hold; a zero divisor is clamped to 1.
module fdiv_prog
  import fdiv_prog_pkg::*;
#(
  parameter int WIDTH       = FDIV_WIDTH_DEF,
  parameter int DEFAULT_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  fdiv_prog_if.slave  bus
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic             fout_q, fout_d;
  logic [WIDTH-1:0] div_clamped;
  logic             term;

  assign div_clamped = (bus.div_in == '0) ? WIDTH'(1) : bus.div_in;
  // div_q is never 0, so div_q-1 cannot wrap
  assign term        = bus.en && (count_q == (div_q - WIDTH'(1)));

  always_comb begin
    count_d = count_q;
    div_d   = div_q;
    tick_d  = 1'b0;
    fout_d  = fout_q;
    if (bus.sync) begin
      count_d = '0;
      fout_d  = 1'b0;
      if (bus.div_load) div_d = div_clamped;
    end else if (bus.div_load) begin
      count_d = '0;
      div_d   = div_clamped;
    end else if (bus.en) begin
      if (term) begin
        count_d = '0;
        tick_d  = 1'b1;
        fout_d  = ~fout_q;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      div_q   <= WIDTH'(DEFAULT_DIV);
      tick_q  <= 1'b0;
      fout_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      fout_q  <= fout_d;
    end
  end

  assign bus.tick    = tick_q;
  assign bus.fout    = fout_q;
  assign bus.div_q   = div_q;
  assign bus.count_q = count_q;

endmodule

// File: tb/tb_fdiv_prog.sv
// Directed bench for fdiv_prog with DEFAULT_DIV=3 and hand-derived expectations.
module tb_fdiv_prog;

  localparam int W = 16;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  fdiv_prog_if #(.WIDTH(W)) bus ();

  fdiv_prog #(.WIDTH(W), .DEFAULT_DIV(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_state(input string tag, input int cnt, input int dv, input int tk, input int fo);
    chk({tag, ".count"}, 32'(bus.count_q), 32'(cnt));
    chk({tag, ".div"},   32'(bus.div_q),   32'(dv));
    chk({tag, ".tick"},  32'(bus.tick),    32'(tk));
    chk({tag, ".fout"},  32'(bus.fout),    32'(fo));
  endtask

  // Reset held for 3 cycles with en=1, then ticks expected at edges 3, 6, 9.
  task automatic reset_sequence(input string tag);
    reset = 1'b0;
    bus.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_state({tag, ".in_rst"}, 0, 3, 0, 0);
    end
    reset = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      cyc();
      chk_state($sformatf("%s.e%0d", tag, e), e % 3, 3, (e % 3 == 0) ? 1 : 0, (e / 3) % 2);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus.en = 1'b0;
    bus.sync = 1'b0;
    bus.div_load = 1'b0;
    bus.div_in = '0;
    @(negedge clk);

    reset_sequence("rst");

    // Runtime load of 5 while count_q=1
    cyc();
    chk_state("pre_load", 1, 3, 0, 1);
    bus.div_load = 1'b1;
    bus.div_in = 16'd5;
    cyc();
    bus.div_load = 1'b0;
    chk_state("load5", 0, 5, 0, 1);
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk_state($sformatf("div5.k%0d", k), k % 5, 5, (k % 5 == 0) ? 1 : 0, 1 ^ ((k / 5) % 2));
    end

    // Zero clamps to divisor 1
    bus.div_load = 1'b1;
    bus.div_in = '0;
    cyc();
    bus.div_load = 1'b0;
    chk_state("load0", 0, 1, 0, 1);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk_state($sformatf("div1.k%0d", k), 0, 1, 1, 1 ^ (k % 2));
    end

    // Enable gating with divisor 4
    bus.div_load = 1'b1;
    bus.div_in = 16'd4;
    cyc();
    bus.div_load = 1'b0;
    chk_state("load4", 0, 4, 0, 1);
    cyc();
    cyc();
    chk_state("run2", 2, 4, 0, 1);
    bus.en = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      chk_state($sformatf("gate.k%0d", k), 2, 4, 0, 1);
    end
    bus.en = 1'b1;
    cyc();
    chk_state("reen1", 3, 4, 0, 1);
    cyc();
    chk_state("reen2", 0, 4, 1, 0);

    // Reach fout=1, count=2, then collide sync and load
    for (int k = 1; k <= 4; k++) cyc();
    chk_state("pre_sync_a", 0, 4, 1, 1);
    cyc();
    cyc();
    chk_state("pre_sync_b", 2, 4, 0, 1);
    bus.sync = 1'b1;
    bus.div_load = 1'b1;
    bus.div_in = 16'd6;
    cyc();
    bus.sync = 1'b0;
    bus.div_load = 1'b0;
    chk_state("sync_load", 0, 6, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk_state($sformatf("div6.k%0d", k), k % 6, 6, (k == 6) ? 1 : 0, (k == 6) ? 1 : 0);
    end

    // Async reset between edges with count=4, fout=1
    for (int k = 1; k <= 4; k++) cyc();
    chk_state("pre_arst", 4, 6, 0, 1);
    #2;
    reset = 1'b0;
    #1;
    chk_state("arst", 0, 3, 0, 0);
    @(negedge clk);
    reset_sequence("rst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
